// File: rtl/regfile8.sv
// 8-entry register file: two combinational read ports, one synchronous write port,
// one hardwired-zero entry. Define REGFILE8_BYPASS_EN to forward write data to reads in the same cycle.
module regfile8 #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned ZERO_REG = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [2:0]       rd_addr_a,
  input  logic [2:0]       rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b
);

  localparam int unsigned     NREGS    = 8;
  localparam int unsigned     AW       = 3;
  localparam logic [AW-1:0]   ZERO_IDX = AW'(ZERO_REG);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [NREGS-1:0] wr_sel_c;
  logic [WIDTH-1:0] stored_a_c;
  logic [WIDTH-1:0] stored_b_c;

  // One-hot write select; the zero entry is never selected.
  always_comb begin
    wr_sel_c           = '0;
    wr_sel_c[wr_addr]  = wr_en;
    wr_sel_c[ZERO_IDX] = 1'b0;
  end

  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_sel_c[i]) begin
        regs_d[i] = wr_data;
      end
    end
    regs_d[ZERO_IDX] = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Zero entry is forced in the read path so it reads 0 even before the first reset.
  always_comb begin
    stored_a_c = regs_q[rd_addr_a];
    if (rd_addr_a == ZERO_IDX) begin
      stored_a_c = '0;
    end
    stored_b_c = regs_q[rd_addr_b];
    if (rd_addr_b == ZERO_IDX) begin
      stored_b_c = '0;
    end
  end

`ifdef REGFILE8_BYPASS_EN
  // wr_sel_c already excludes the zero entry, so forwarding never targets it.
  always_comb begin
    rd_data_a = stored_a_c;
    rd_data_b = stored_b_c;
    if (reset_n && wr_sel_c[rd_addr_a]) begin
      rd_data_a = wr_data;
    end
    if (reset_n && wr_sel_c[rd_addr_b]) begin
      rd_data_b = wr_data;
    end
  end
`else
  always_comb begin
    rd_data_a = stored_a_c;
    rd_data_b = stored_b_c;
  end
`endif

endmodule

// File: tb/tb_regfile8.sv
// Self-checking bench for regfile8: a per-cycle reference model plus directed literal checks.
module tb_regfile8;

  localparam int unsigned WIDTH = 64;

  logic             clk;
  logic             reset_n;
  logic             wr_en;
  logic [2:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [2:0]       rd_addr_a;
  logic [2:0]       rd_addr_b;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;

  int n_tests = 0;
  int n_fail  = 0;
  bit model_ok = 1'b0;
  logic [WIDTH-1:0] model [8];

`ifdef REGFILE8_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  regfile8 #(.WIDTH(WIDTH), .ZERO_REG(7)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // What a port must show: zero entry is 0, a live write may forward, else the stored value.
  function automatic logic [WIDTH-1:0] expect_rd(input logic [2:0] addr);
    if (addr == 3'd7) return '0;
    if (BYPASS && reset_n && wr_en && wr_addr == addr) return wr_data;
    return model[addr];
  endfunction

  // Reference state: reset clears everything, writes to 7 are dropped.
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) model[i] = '0;
      model_ok = 1'b1;
    end else if (wr_en && wr_addr != 3'd7) begin
      model[wr_addr] = wr_data;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("model_a", rd_data_a, expect_rd(rd_addr_a));
      check("model_b", rd_data_b, expect_rd(rd_addr_b));
    end
  end

  task automatic drive(input logic rst, input logic we, input logic [2:0] wa,
                       input logic [WIDTH-1:0] wd, input logic [2:0] ra, input logic [2:0] rb);
    @(posedge clk);
    #1;
    reset_n = rst; wr_en = we; wr_addr = wa; wr_data = wd; rd_addr_a = ra; rd_addr_b = rb;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;

    // Reset held while sweeping both ports over every address.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 3'd0, '0, 3'(i), 3'(7 - i));
      check("rst_rd_a", rd_data_a, '0);
      check("rst_rd_b", rd_data_b, '0);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 3'd0, '0, 3'(i), 3'(i));
      check("post_rst_a", rd_data_a, '0);
      check("post_rst_b", rd_data_b, '0);
    end

    drive(1'b1, 1'b1, 3'd3, 64'h0123_4567_89AB_CDEF, 3'd0, 3'd1);
    drive(1'b1, 1'b0, 3'd0, '0, 3'd3, 3'd3);
    check("r3_a", rd_data_a, 64'h0123_4567_89AB_CDEF);
    check("r3_b", rd_data_b, 64'h0123_4567_89AB_CDEF);
    drive(1'b1, 1'b0, 3'd0, '0, 3'd2, 3'd4);
    check("r2_zero", rd_data_a, '0);
    check("r4_zero", rd_data_b, '0);

    drive(1'b1, 1'b1, 3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 3'd7, 3'd3);
    check("r7_fwd_none", rd_data_a, '0);
    drive(1'b1, 1'b0, 3'd0, '0, 3'd7, 3'd3);
    check("r7_zero", rd_data_a, '0);
    check("r3_kept", rd_data_b, 64'h0123_4567_89AB_CDEF);

    drive(1'b1, 1'b1, 3'd5, 64'h11, 3'd0, 3'd0);
    drive(1'b1, 1'b1, 3'd5, 64'hAA, 3'd5, 3'd3);
    check("same_cyc_r5", rd_data_a, BYPASS ? 64'hAA : 64'h11);
    drive(1'b1, 1'b0, 3'd0, '0, 3'd5, 3'd5);
    check("after_r5_a", rd_data_a, 64'hAA);
    check("after_r5_b", rd_data_b, 64'hAA);

    drive(1'b1, 1'b1, 3'd2, 64'h99, 3'd0, 3'd0);
    drive(1'b0, 1'b1, 3'd2, 64'h55, 3'd2, 3'd5);
    check("rst_wr_nofwd", rd_data_a, 64'h99);
    drive(1'b1, 1'b0, 3'd0, '0, 3'd2, 3'd5);
    check("rst_wr_drop", rd_data_a, '0);
    check("rst_clr_r5", rd_data_b, '0);

    // Walk r0..r6 with port B trailing by one address.
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 3'(i), WIDTH'(64'h10 + 64'(i)), 3'(i), 3'(i == 0 ? 7 : i - 1));
      check("walk_b", rd_data_b, (i == 0) ? '0 : WIDTH'(64'h10 + 64'(i - 1)));
    end
    drive(1'b1, 1'b0, 3'd0, '0, 3'd7, 3'd6);
    check("walk_r7", rd_data_a, '0);
    check("walk_r6", rd_data_b, 64'h16);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 3'd0, '0, 3'(i), 3'(i));
      check("walk_rb", rd_data_a, WIDTH'(64'h10 + 64'(i)));
    end

    // Mixed traffic, checked by the model every cycle.
    for (int i = 0; i < 60; i++) begin
      drive((i % 23) != 22, 1'($urandom), 3'($urandom), {$urandom, $urandom},
            3'($urandom), 3'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile8.md
REGFILE8 -- requirements
Module: regfile8

Interface
REQ-001 The block SHALL take parameter WIDTH, default 64, as the data width of each register and of every data port.
REQ-002 The block SHALL take parameter ZERO_REG, default 7, as the register index that reads as constant zero (range 0..7).
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1, SHALL be the synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 Port wr_en, input, 1, SHALL be the write enable.
REQ-006 Port wr_addr, input, 3, SHALL be the write register index.
REQ-007 Port wr_data, input, WIDTH, SHALL be the write data.
REQ-008 Port rd_addr_a, input, 3, SHALL be the read port A register index.
REQ-009 Port rd_addr_b, input, 3, SHALL be the read port B register index.
REQ-010 Port rd_data_a, output, WIDTH, SHALL be the read port A data.
REQ-011 Port rd_data_b, output, WIDTH, SHALL be the read port B data.

Function
REQ-012 The block SHALL hold 8 registers of WIDTH bits each, r0..r7.
REQ-013 Write timing: on a rising clk with reset_n=1 and wr_en=1, r[wr_addr] SHALL be loaded with wr_data; all other registers SHALL hold.
REQ-014 Write disable: with wr_en=0, no register SHALL change.
REQ-015 Zero register: a write to index ZERO_REG SHALL be discarded, and r[ZERO_REG] SHALL read as all zeros at all times.
REQ-016 Write decode: the write enable SHALL be a one-hot 3-to-8 decode of wr_addr gated by wr_en; at most one register SHALL be written per cycle.
REQ-017 Read path: each read port SHALL be combinational, formed per bit as an 8-to-1 selection over r0..r7 indexed by its address, with zero latency from address change.
REQ-018 Read ports: ports A and B SHALL be independent; equal addresses on both ports SHALL return identical data.
REQ-019 Write visibility: without bypass (see REQ-025), data written at edge N SHALL appear on a read port addressing that register immediately after edge N; before the edge, the port SHALL show the old value.
REQ-020 Determinism: no output SHALL be X/Z after the first reset cycle for any in-range input.

Reset
REQ-021 With reset_n=0 at a rising clk, all eight registers SHALL clear to 0, regardless of wr_en.
REQ-022 While reset is asserted, rd_data_a and rd_data_b SHALL read 0 for every address from the first reset edge onward.
REQ-023 Reset mid-operation: a write coincident with reset_n=0 SHALL be discarded.
REQ-024 On the first edge with reset_n=1, writes SHALL resume normally.

Configuration
REQ-025 Macro REGFILE8_BYPASS_EN, when defined, SHALL enable same-cycle forwarding.
- With forwarding: if wr_en=1, reset_n=1, wr_addr equals a read address, and wr_addr is not ZERO_REG, that read port SHALL output wr_data combinationally in the same cycle.
- Without forwarding: the read ports SHALL show stored register contents only (REQ-019).
- Forwarding SHALL never apply to ZERO_REG or while reset_n=0.

Verification
REQ-026 Reset and readback: hold reset_n=0 for 2 cycles, then read all 8 addresses on both ports -> 0 everywhere.
REQ-027 Write and readback: write r3=0x0123_4567_89AB_CDEF; next cycle set rd_addr_a=3, rd_addr_b=3 -> both ports show 0x0123_4567_89AB_CDEF; other registers still 0.
REQ-028 Zero register write: write r7=0xFFFF_FFFF_FFFF_FFFF, then read r7 -> 0; r0..r6 unchanged.
REQ-029 Write during reset: reset_n=0 with wr_en=1, wr_addr=2, wr_data=0x55 -> r2 reads 0 after reset is released.
REQ-030 Simultaneous write and read: wr_en=1, wr_addr=5, wr_data=0xAA, rd_addr_a=5, with r5 previously 0x11 -> same cycle rd_data_a=0xAA with REGFILE8_BYPASS_EN and 0x11 without it; rd_data_a=0xAA after the edge in both builds.
REQ-031 Walk all registers: write r0..r6 with values 0x10..0x16 on consecutive cycles while port B trails by one address -> each read matches its written value, and r7 reads 0.
